// File: rtl/display_pkg.sv
// Shared constants for the debug display path: view indices and sequencer state encoding.
package display_pkg;
    localparam int NUM_VIEWS_DEFAULT = 24;

    localparam logic [4:0] VIEW_STAGE   = 5'd0;
    localparam logic [4:0] VIEW_PC      = 5'd1;
    localparam logic [4:0] VIEW_IR      = 5'd2;
    localparam logic [4:0] VIEW_CCF     = 5'd3;
    localparam logic [4:0] VIEW_RF_ADDR = 5'd4;
    localparam logic [4:0] VIEW_RF_REG  = 5'd23;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_HOLD   = 2'd2
    } seq_state_t;
endpackage

// File: rtl/button_debouncer.sv
// Active-low pushbutton: 2-FF synchronizer, stable-count debouncer, one-cycle press pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          raw;

    assign raw = ~sync2;

    // Synchronizer resets to the released (high) level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (raw != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= raw;
                    cnt   <= '0;
                    press <= raw;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/display_select_sequencer.sv
// Steps the debug display view index from keys, direct loads and an auto-scroll timer; blanks on freeze.
module display_select_sequencer
    import display_pkg::*;
#(
    parameter int NUM_VIEWS       = NUM_VIEWS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 50000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       KEY_Next_n,
    input  logic       KEY_Prev_n,
    input  logic       Auto_Mode,
    input  logic       Freeze,
    input  logic       Direct_Load,
    input  logic [4:0] Direct_Select,
    output logic [4:0] Display_Select,
    output logic       Display_Enable,
    output logic       Select_Changed,
    output logic       Load_Reject
);
    localparam logic [4:0] LAST = 5'(NUM_VIEWS - 1);
    localparam int         ACW  = $clog2(AUTO_PERIOD + 1);

    seq_state_t     state, state_nxt;
    logic           next_ev, prev_ev;
    logic [ACW-1:0] auto_cnt, auto_cnt_nxt;
    logic [4:0]     sel_nxt, sel_inc, sel_dec;
    logic           reject_nxt, restart;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(Clock), .rst(Reset), .key_n(KEY_Next_n), .press(next_ev));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk(Clock), .rst(Reset), .key_n(KEY_Prev_n), .press(prev_ev));

    assign sel_inc        = (Display_Select == LAST)  ? 5'd0 : Display_Select + 5'd1;
    assign sel_dec        = (Display_Select == 5'd0)  ? LAST : Display_Select - 5'd1;
    assign Display_Enable = (state == ST_HOLD);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= ST_MANUAL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = ST_MANUAL;
        sel_nxt      = Display_Select;
        reject_nxt   = 1'b0;
        restart      = 1'b0;
        auto_cnt_nxt = '0;

        if (Freeze)         state_nxt = ST_HOLD;
        else if (Auto_Mode) state_nxt = ST_AUTO;

        if (state != ST_HOLD) begin
            if (Direct_Load) begin
                if ({1'b0, Direct_Select} < 6'(NUM_VIEWS)) begin
                    sel_nxt = Direct_Select;
                    restart = 1'b1;
                end else begin
                    reject_nxt = 1'b1;
                end
            end else if (next_ev && prev_ev) begin
                sel_nxt = Display_Select;
            end else if (next_ev) begin
                sel_nxt = sel_inc;
                restart = 1'b1;
            end else if (prev_ev) begin
                sel_nxt = sel_dec;
                restart = 1'b1;
            end else if (state == ST_AUTO && auto_cnt == ACW'(AUTO_PERIOD - 1)) begin
                sel_nxt = sel_inc;
                restart = 1'b1;
            end
        end

        // Counter only runs in AUTO, so it is already 0 whenever AUTO is entered.
        if (state == ST_AUTO && !restart) auto_cnt_nxt = auto_cnt + 1'b1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Display_Select <= 5'd0;
            Select_Changed <= 1'b0;
            Load_Reject    <= 1'b0;
            auto_cnt       <= '0;
        end else begin
            Display_Select <= sel_nxt;
            Select_Changed <= (sel_nxt != Display_Select);
            Load_Reject    <= reject_nxt;
            auto_cnt       <= auto_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_display_select_sequencer.sv
// Directed bench: load vector table plus hand sequences for debounce, wrap, auto-scroll, freeze and reset.
module tb_display_select_sequencer;
    logic       Clock = 1'b0;
    logic       Reset;
    logic       KEY_Next_n, KEY_Prev_n, Auto_Mode, Freeze, Direct_Load;
    logic [4:0] Direct_Select;
    logic [4:0] Display_Select;
    logic       Display_Enable, Select_Changed, Load_Reject;

    int checks   = 0;
    int failures = 0;
    int chg_cnt  = 0;

    typedef struct {
        logic       load;
        logic [4:0] sel_in;
        logic [4:0] exp_sel;
        logic       exp_chg;
        logic       exp_rej;
    } vec_t;

    vec_t vecs[8];
    int   auto_n[6];
    int   auto_exp[6];

    display_select_sequencer #(
        .NUM_VIEWS(24), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(10)
    ) dut (
        .Clock(Clock), .Reset(Reset), .KEY_Next_n(KEY_Next_n), .KEY_Prev_n(KEY_Prev_n),
        .Auto_Mode(Auto_Mode), .Freeze(Freeze), .Direct_Load(Direct_Load),
        .Direct_Select(Direct_Select), .Display_Select(Display_Select),
        .Display_Enable(Display_Enable), .Select_Changed(Select_Changed),
        .Load_Reject(Load_Reject));

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        if (Select_Changed) chg_cnt++;
    endtask

    task automatic hold_keys(input bit nxt, input bit prv, input int cycles);
        chg_cnt = 0;
        KEY_Next_n = ~nxt;
        KEY_Prev_n = ~prv;
        repeat (cycles) tick();
        KEY_Next_n = 1'b1;
        KEY_Prev_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic load(input logic [4:0] v);
        Direct_Load = 1'b1;
        Direct_Select = v;
        tick();
        Direct_Load = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd17, 5'd17, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 5'd30, 5'd17, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 5'd17, 5'd17, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd23, 5'd23, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 5'd24, 5'd23, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b0};
        vecs[6] = '{1'b1, 5'd31, 5'd0,  1'b0, 1'b1};
        vecs[7] = '{1'b1, 5'd5,  5'd5,  1'b1, 1'b0};
        // Auto advance at edge 11; key press at 11 steps at 18 and restarts; next auto at 28.
        auto_n   = '{10, 11, 17, 18, 27, 28};
        auto_exp = '{5,  6,  6,  7,  7,  8};

        Reset = 1'b1;
        KEY_Next_n = 1'b1; KEY_Prev_n = 1'b1;
        Auto_Mode = 1'b0; Freeze = 1'b0; Direct_Load = 1'b0; Direct_Select = 5'd0;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_sel", 32'(Display_Select), 0);
        check("reset_en", 32'(Display_Enable), 0);
        check("reset_chg", 32'(Select_Changed), 0);
        check("reset_rej", 32'(Load_Reject), 0);
        Reset = 1'b0;
        tick(); tick();
        check("post_reset_sel", 32'(Display_Select), 0);

        // bounced press, never 4 consecutive low cycles
        chg_cnt = 0;
        KEY_Next_n = 1'b0; tick(); tick();
        KEY_Next_n = 1'b1; tick();
        KEY_Next_n = 1'b0; tick(); tick(); tick();
        KEY_Next_n = 1'b1; repeat (10) tick();
        check("bounce_pulses", 32'(chg_cnt), 0);
        check("bounce_sel", 32'(Display_Select), 0);

        hold_keys(1'b1, 1'b0, 10);
        check("next_pulses", 32'(chg_cnt), 1);
        check("next_sel", 32'(Display_Select), 1);

        load(5'd23);
        check("load23_sel", 32'(Display_Select), 23);
        hold_keys(1'b1, 1'b0, 10);
        check("wrap_next_sel", 32'(Display_Select), 0);
        check("wrap_next_pulses", 32'(chg_cnt), 1);
        hold_keys(1'b0, 1'b1, 10);
        check("wrap_prev_sel", 32'(Display_Select), 23);
        check("wrap_prev_pulses", 32'(chg_cnt), 1);
        hold_keys(1'b1, 1'b1, 10);
        check("both_sel", 32'(Display_Select), 23);
        check("both_pulses", 32'(chg_cnt), 0);

        for (int i = 0; i < 8; i++) begin
            Direct_Load = vecs[i].load;
            Direct_Select = vecs[i].sel_in;
            tick();
            check($sformatf("vec%0d_sel", i), 32'(Display_Select), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_chg", i), 32'(Select_Changed), 32'(vecs[i].exp_chg));
            check($sformatf("vec%0d_rej", i), 32'(Load_Reject), 32'(vecs[i].exp_rej));
            Direct_Load = 1'b0;
            tick();
            check($sformatf("vec%0d_chg_end", i), 32'(Select_Changed), 0);
            check($sformatf("vec%0d_rej_end", i), 32'(Load_Reject), 0);
        end

        // auto-scroll from 5 with a Next press restarting the period
        chg_cnt = 0;
        Auto_Mode = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            for (int k = 0; k < 6; k++)
                if (auto_n[k] == n)
                    check($sformatf("auto_edge%0d", n), 32'(Display_Select), 32'(auto_exp[k]));
            if (n == 11) KEY_Next_n = 1'b0;
            if (n == 21) KEY_Next_n = 1'b1;
        end
        check("auto_pulses", 32'(chg_cnt), 3);
        Auto_Mode = 1'b0;
        repeat (15) tick();
        check("manual_no_auto", 32'(Display_Select), 8);

        // freeze: blank, ignore loads/keys/auto
        Freeze = 1'b1;
        tick();
        check("freeze_en", 32'(Display_Enable), 1);
        Direct_Load = 1'b1; Direct_Select = 5'd10;
        tick();
        check("freeze_load_sel", 32'(Display_Select), 8);
        Direct_Select = 5'd30;
        tick();
        check("freeze_rej", 32'(Load_Reject), 0);
        Direct_Load = 1'b0;
        Auto_Mode = 1'b1;
        hold_keys(1'b1, 1'b0, 10);
        repeat (10) tick();
        check("freeze_key_sel", 32'(Display_Select), 8);
        check("freeze_en_hold", 32'(Display_Enable), 1);
        Auto_Mode = 1'b0;
        Freeze = 1'b0;
        tick();
        check("unfreeze_en", 32'(Display_Enable), 0);
        check("unfreeze_sel", 32'(Display_Select), 8);

        // async reset between edges while frozen
        Freeze = 1'b1;
        tick();
        #3 Reset = 1'b1;
        #1;
        check("async_rst_sel", 32'(Display_Select), 0);
        check("async_rst_en", 32'(Display_Enable), 0);
        Freeze = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        check("rst_release_en", 32'(Display_Enable), 0);
        Direct_Load = 1'b1; Direct_Select = 5'd3;
        tick();
        Direct_Load = 1'b0;
        check("rst_manual_load", 32'(Display_Select), 3);
        check("rst_manual_chg", 32'(Select_Changed), 1);
        repeat (15) tick();
        check("rst_manual_hold", 32'(Display_Select), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
